// File: rtl/dtree_pkg.sv
// Shared types and the trained node table for the sequential decision-tree evaluator.
package dtree_pkg;

  localparam int DT_N_FEAT  = 7;
  localparam int DT_FEAT_W  = 8;
  localparam int DT_CLASS_W = 5;
  localparam int DT_NODE_AW = 4;
  localparam int DT_FIDX_W  = 3;
  localparam int DT_SHIFT_W = 3;
  localparam int DT_N_NODES = 1 << DT_NODE_AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic                  leaf;
    logic [DT_CLASS_W-1:0] cls;
    logic [DT_FIDX_W-1:0]  feat_idx;
    logic [DT_SHIFT_W-1:0] shift;
    logic [DT_FEAT_W-1:0]  thr;
    logic [DT_NODE_AW-1:0] left;
    logic [DT_NODE_AW-1:0] right;
  } node_t;

  typedef node_t [DT_N_NODES-1:0] node_tab_t;

  function automatic node_t mk_leaf(input logic [DT_CLASS_W-1:0] cls);
    node_t n;
    n      = '0;
    n.leaf = 1'b1;
    n.cls  = cls;
    return n;
  endfunction

  function automatic node_t mk_int(input logic [DT_FIDX_W-1:0]  fidx,
                                   input logic [DT_SHIFT_W-1:0] sh,
                                   input logic [DT_FEAT_W-1:0]  thr,
                                   input logic [DT_NODE_AW-1:0] l,
                                   input logic [DT_NODE_AW-1:0] r);
    node_t n;
    n          = '0;
    n.feat_idx = fidx;
    n.shift    = sh;
    n.thr      = thr;
    n.left     = l;
    n.right    = r;
    return n;
  endfunction

  // Unused slots are all-zero: internal nodes pointing back to the root,
  // so a corrupt pointer ends in the depth abort rather than a bogus class.
  function automatic node_tab_t build_tree();
    node_tab_t t;
    t    = '0;
    t[0] = mk_int(3'd6, 3'd5, 8'd0, 4'd1, 4'd2);
    t[1] = mk_leaf(5'd3);
    t[2] = mk_int(3'd1, 3'd6, 8'd1, 4'd3, 4'd4);
    t[3] = mk_leaf(5'd7);
    t[4] = mk_leaf(5'd12);
    return t;
  endfunction

  // Degenerate table whose root loops onto itself; exercises the depth abort.
  function automatic node_tab_t build_loop();
    node_tab_t t;
    t    = '0;
    t[0] = mk_int(3'd0, 3'd0, 8'd0, 4'd0, 4'd0);
    return t;
  endfunction

  localparam node_tab_t NODE_TABLE = build_tree();
  localparam node_tab_t LOOP_TABLE = build_loop();

endpackage

// File: rtl/dtree_node_rom.sv
// Combinational node-table lookup: address in, node word out.
module dtree_node_rom
  import dtree_pkg::*;
#(
  parameter node_tab_t TABLE = NODE_TABLE
) (
  input  logic [DT_NODE_AW-1:0] addr,
  output node_t                 node
);

  assign node = TABLE[addr];

endmodule

// File: rtl/dtree_seq_eval.sv
// Sequential decision-tree evaluator: walks the node table one node per cycle
// through a single shared shift-and-compare unit.
module dtree_seq_eval
  import dtree_pkg::*;
#(
  parameter int        N_FEAT    = DT_N_FEAT,
  parameter int        FEAT_W    = DT_FEAT_W,
  parameter int        CLASS_W   = DT_CLASS_W,
  parameter int        NODE_AW   = DT_NODE_AW,
  parameter int        MAX_DEPTH = 15,
  parameter node_tab_t TABLE     = NODE_TABLE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_FEAT*FEAT_W-1:0] in_feat,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CLASS_W-1:0]       out_class,
  output logic                     out_err,
  output logic                     busy
);

  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

  state_t                         state, state_nxt;
  logic [N_FEAT-1:0][FEAT_W-1:0]  feat_q;
  logic [NODE_AW-1:0]             node_q;
  logic [DEPTH_W-1:0]             depth_q;
  node_t                          nd;
  logic [FEAT_W-1:0]              fsel;
  logic [FEAT_W-1:0]              fshift;
  logic                           go_left;
  logic                           at_limit;

  dtree_node_rom #(.TABLE(TABLE)) u_rom (
    .addr (node_q),
    .node (nd)
  );

  // Feature mux; an index past the last feature reads as zero.
  always_comb begin
    fsel = '0;
    for (int i = 0; i < N_FEAT; i++)
      if (int'(nd.feat_idx) == i) fsel = feat_q[i];
  end

  assign fshift   = fsel >> nd.shift;
  assign go_left  = (fshift <= nd.thr);
  assign at_limit = (depth_q == DEPTH_W'(MAX_DEPTH));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a result is held in DONE until the consumer takes it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)             state_nxt = EVAL;
      EVAL:    if (nd.leaf || at_limit)  state_nxt = DONE;
      DONE:    if (out_ready)            state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // Datapath: feature capture on handshake, node/depth walk, result latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feat_q    <= '0;
      node_q    <= '0;
      depth_q   <= '0;
      out_class <= '0;
      out_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          feat_q  <= in_feat;
          node_q  <= '0;
          depth_q <= '0;
        end
        EVAL: begin
          if (nd.leaf) begin
            out_class <= nd.cls;
            out_err   <= 1'b0;
          end else if (at_limit) begin
            out_class <= '0;
            out_err   <= 1'b1;
          end else begin
            node_q  <= go_left ? nd.left : nd.right;
            depth_q <= depth_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == EVAL);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_dtree_seq_eval.sv
// Directed bench for dtree_seq_eval: test tree on one instance, looping table on another.
module tb_dtree_seq_eval;
  import dtree_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [55:0] in_feat = '0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid, out_err, busy;
  logic [4:0]  out_class;
  logic        l_valid = 1'b0, l_ready = 1'b0;
  logic        l_in_ready, l_out_valid, l_err, l_busy;
  logic [4:0]  l_class;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dtree_seq_eval dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_feat(in_feat), .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_err(out_err), .busy(busy)
  );

  dtree_seq_eval #(.TABLE(LOOP_TABLE)) dut_loop (
    .clk(clk), .rst_n(rst_n), .in_valid(l_valid), .in_ready(l_in_ready),
    .in_feat(in_feat), .out_valid(l_out_valid), .out_ready(l_ready),
    .out_class(l_class), .out_err(l_err), .busy(l_busy)
  );

  task automatic test_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, busy, out_err, out_class} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0}) begin
      $display("FAIL reset_hold: got rdy/vld/busy/err/cls=%b%b%b%b/%0d want 1000/0",
               in_ready, out_valid, busy, out_err, out_class);
      n_err++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, out_valid, busy, out_err, out_class} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0}) begin
      $display("FAIL reset_release: got rdy/vld/busy/err/cls=%b%b%b%b/%0d want 1000/0",
               in_ready, out_valid, busy, out_err, out_class);
      n_err++;
    end
    n_cmp++;
    if ({l_in_ready, l_out_valid, l_busy, l_err, l_class} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0}) begin
      $display("FAIL reset_loop_inst: got rdy/vld/busy/err/cls=%b%b%b%b/%0d want 1000/0",
               l_in_ready, l_out_valid, l_busy, l_err, l_class);
      n_err++;
    end
  endtask

  // Left leaf, deep left, deep right; in_feat is scrambled after each handshake.
  task automatic test_classify();
    logic [7:0] f6 [3];
    logic [7:0] f1 [3];
    logic [4:0] ecls [3];
    int         elat [3];
    int         lat;
    f6   = '{8'h1F, 8'h40, 8'h40};
    f1   = '{8'h00, 8'h7F, 8'h80};
    ecls = '{5'd3, 5'd7, 5'd12};
    elat = '{2, 3, 3};
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (in_ready !== 1'b1) begin
        $display("FAIL cls%0d_in_ready: got %b want 1", i, in_ready); n_err++;
      end
      in_feat = '0; in_feat[48 +: 8] = f6[i]; in_feat[8 +: 8] = f1[i]; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0; in_feat = '1;
      n_cmp++;
      if ({busy, in_ready} !== 2'b10) begin
        $display("FAIL cls%0d_busy: got busy/rdy=%b%b want 10", i, busy, in_ready); n_err++;
      end
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
      n_cmp++;
      if (lat != elat[i]) begin
        $display("FAIL cls%0d_latency: got %0d want %0d", i, lat, elat[i]); n_err++;
      end
      n_cmp++;
      if ({out_err, out_class} !== {1'b0, ecls[i]}) begin
        $display("FAIL cls%0d_result: got err=%b cls=%0d want err=0 cls=%0d", i, out_err, out_class, ecls[i]);
        n_err++;
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_cmp++;
      if ({in_ready, out_valid} !== 2'b10) begin
        $display("FAIL cls%0d_release: got rdy/vld=%b%b want 10", i, in_ready, out_valid); n_err++;
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    in_feat = '0; in_feat[48 +: 8] = 8'h1F; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if ({out_valid, in_ready, out_err, out_class} !== {1'b1, 1'b0, 1'b0, 5'd3}) begin
        $display("FAIL bp_hold%0d: got vld/rdy/err/cls=%b%b%b/%0d want 100/3",
                 c, out_valid, in_ready, out_err, out_class);
        n_err++;
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b10) begin
      $display("FAIL bp_release: got rdy/vld=%b%b want 10", in_ready, out_valid); n_err++;
    end
  endtask

  // out_ready held high: in_ready returns d+2 negedges after the handshake.
  task automatic test_back_to_back();
    logic [7:0] f6 [2];
    logic [7:0] f1 [2];
    logic [4:0] ecls [2];
    int         egap [2];
    int         cnt;
    logic [4:0] cap;
    f6 = '{8'h1F, 8'h40}; f1 = '{8'h00, 8'h80};
    ecls = '{5'd3, 5'd12}; egap = '{3, 4};
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_feat = '0; in_feat[48 +: 8] = f6[i]; in_feat[8 +: 8] = f1[i]; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      cnt = 0; cap = 5'h1F;
      while (in_ready !== 1'b1 && cnt < 40) begin
        if (out_valid === 1'b1) cap = out_class;
        @(negedge clk); cnt++;
      end
      n_cmp++;
      if (cnt != egap[i]) begin
        $display("FAIL b2b%0d_gap: got %0d want %0d", i, cnt, egap[i]); n_err++;
      end
      n_cmp++;
      if (cap !== ecls[i]) begin
        $display("FAIL b2b%0d_class: got %0d want %0d", i, cap, ecls[i]); n_err++;
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_loop();
    int lat;
    in_feat = '0; l_valid = 1'b1;
    @(negedge clk);
    l_valid = 1'b0;
    n_cmp++;
    if (l_busy !== 1'b1) begin
      $display("FAIL loop_busy: got %b want 1", l_busy); n_err++;
    end
    lat = 0;
    while (l_out_valid !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
    n_cmp++;
    if (lat != 16) begin
      $display("FAIL loop_latency: got %0d want 16", lat); n_err++;
    end
    n_cmp++;
    if ({l_err, l_class} !== {1'b1, 5'd0}) begin
      $display("FAIL loop_result: got err=%b cls=%0d want err=1 cls=0", l_err, l_class); n_err++;
    end
    l_ready = 1'b1;
    @(negedge clk);
    l_ready = 1'b0;
    n_cmp++;
    if ({l_in_ready, l_out_valid} !== 2'b10) begin
      $display("FAIL loop_release: got rdy/vld=%b%b want 10", l_in_ready, l_out_valid); n_err++;
    end
  endtask

  task automatic test_mid_reset();
    logic seen;
    int   lat;
    in_feat = '0; in_feat[48 +: 8] = 8'h40; in_feat[8 +: 8] = 8'h80; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin
      $display("FAIL mr_busy_before: got %b want 1", busy); n_err++;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, out_valid, busy, out_err, out_class} !== {1'b1, 1'b0, 1'b0, 1'b0, 5'd0}) begin
      $display("FAIL mr_immediate: got rdy/vld/busy/err/cls=%b%b%b%b/%0d want 1000/0",
               in_ready, out_valid, busy, out_err, out_class);
      n_err++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      $display("FAIL mr_no_result: got stray valid/busy=%b want 0", seen); n_err++;
    end
    in_feat = '0; in_feat[48 +: 8] = 8'h40; in_feat[8 +: 8] = 8'h7F; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    n_cmp++;
    if (lat != 3 || out_class !== 5'd7 || out_err !== 1'b0) begin
      $display("FAIL mr_next_vector: got lat=%0d cls=%0d err=%b want lat=3 cls=7 err=0",
               lat, out_class, out_err);
      n_err++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_classify();
    test_backpressure();
    test_back_to_back();
    test_loop();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
